// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, opcode field and the fetch-stage state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [5:0]  opcode_t;

  localparam opcode_t HALT_OPCODE = 6'b111111;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: icache request/response, hazard/redirect controls and IF/ID outputs.
interface fetch_unit_if;
  import cpu_types_pkg::*;

  logic  ihit;
  word_t iload;
  logic  stall;
  logic  redirect_valid;
  word_t redirect_pc;
  logic  imemREN;
  word_t imemaddr;
  word_t ifinstr;
  word_t ifJALjump_addr;
  logic  ifW;
  logic  ifRST;

  modport master (
    input  ihit, iload, stall, redirect_valid, redirect_pc,
    output imemREN, imemaddr, ifinstr, ifJALjump_addr, ifW, ifRST
  );

  modport slave (
    output ihit, iload, stall, redirect_valid, redirect_pc,
    input  imemREN, imemaddr, ifinstr, ifJALjump_addr, ifW, ifRST
  );
endinterface

// File: rtl/fetch_unit_pc_reg.sv
// PC register plus the pending-redirect slot used when a redirect lands during a miss.
module pc_reg
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  pc_load,
  input  word_t pc_next,
  input  logic  pend_set,
  input  logic  pend_clr,
  input  word_t pend_pc_in,
  output word_t pc,
  output logic  pend,
  output word_t pend_pc
);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      pc      <= PC_INIT;
      pend    <= 1'b0;
      pend_pc <= '0;
    end else begin
      if (pc_load)
        pc <= pc_next;
      // A newer redirect overwrites an older pending one.
      if (pend_set) begin
        pend    <= 1'b1;
        pend_pc <= pend_pc_in;
      end else if (pend_clr) begin
        pend    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the icache and feeds the IF/ID register,
// with a one-entry hold buffer for stalls, redirect handling and halt.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t   PC_INIT = 32'h0000_0000,
  parameter opcode_t HALT_OP = HALT_OPCODE
) (
  input logic          CLK,
  input logic          nRST,
  fetch_unit_if.master bus
);

  fetch_state_t state, next_state;
  word_t        pc, pend_pc, pc_next, pc_plus4, redirect_target, hold_buf;
  logic         pend, pc_load, pend_set, pend_clr, buf_load;
  logic         ren_c, ifw_c, ifrst_c;

  assign pc_plus4        = pc + 32'd4;
  assign redirect_target = bus.redirect_pc & ~32'h3;

  pc_reg #(.PC_INIT(PC_INIT)) u_pc_reg (
    .CLK        (CLK),
    .nRST       (nRST),
    .pc_load    (pc_load),
    .pc_next    (pc_next),
    .pend_set   (pend_set),
    .pend_clr   (pend_clr),
    .pend_pc_in (redirect_target),
    .pc         (pc),
    .pend       (pend),
    .pend_pc    (pend_pc)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state    <= FETCH;
      hold_buf <= '0;
    end else begin
      state <= next_state;
      if (buf_load)
        hold_buf <= bus.iload;
    end
  end

  // Priority is redirect, then a pending redirect, then stall.
  always_comb begin
    next_state = state;
    ren_c      = 1'b0;
    ifw_c      = 1'b0;
    ifrst_c    = 1'b0;
    pc_load    = 1'b0;
    pc_next    = pc_plus4;
    pend_set   = 1'b0;
    pend_clr   = 1'b0;
    buf_load   = 1'b0;
    unique case (state)
      FETCH: begin
        ren_c = 1'b1;
        if (bus.redirect_valid) begin
          ifw_c   = 1'b1;
          ifrst_c = 1'b1;
          if (bus.ihit) begin
            pc_load  = 1'b1;
            pc_next  = redirect_target;
            pend_clr = 1'b1;
          end else begin
            pend_set = 1'b1;
          end
        end else if (bus.ihit && pend) begin
          pc_load  = 1'b1;
          pc_next  = pend_pc;
          pend_clr = 1'b1;
        end else if (bus.ihit && !bus.stall) begin
          ifw_c   = 1'b1;
          pc_load = 1'b1;
          if (bus.iload[31:26] == HALT_OP)
            next_state = HALTED;
        end else if (bus.ihit) begin
          buf_load   = 1'b1;
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (bus.redirect_valid) begin
          ifw_c      = 1'b1;
          ifrst_c    = 1'b1;
          pc_load    = 1'b1;
          pc_next    = redirect_target;
          next_state = FETCH;
        end else if (!bus.stall) begin
          ifw_c      = 1'b1;
          pc_load    = 1'b1;
          next_state = (hold_buf[31:26] == HALT_OP) ? HALTED : FETCH;
        end
      end
      HALTED: begin
        if (bus.redirect_valid) begin
          ifw_c      = 1'b1;
          ifrst_c    = 1'b1;
          pc_load    = 1'b1;
          pc_next    = redirect_target;
          next_state = FETCH;
        end
      end
      default: next_state = FETCH;
    endcase
  end

  assign bus.imemREN        = ren_c   & nRST;
  assign bus.ifW            = ifw_c   & nRST;
  assign bus.ifRST          = ifrst_c & nRST;
  assign bus.imemaddr       = pc;
  assign bus.ifinstr        = (state == HOLD) ? hold_buf : bus.iload;
  assign bus.ifJALjump_addr = pc_plus4;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the pipelined MIPS core. Sits directly upstream of the IF/ID pipeline register.
- Owns the PC and drives the icache request. Produces the fetched instruction, its PC+4 (JAL link value), and the write/flush controls for IF/ID.
- Handles hazard-unit stalls with a one-entry hold buffer, branch/jump redirects (including a redirect that arrives while a miss is outstanding), and halt.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.
- HALT_OP, 6'b111111, opcode that stops fetching.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, synchronous, active-low.
- ihit  in  1  icache returns a valid word this cycle for imemaddr.
- iload  in  32  icache read data, valid when ihit=1.
- stall  in  1  hazard unit: IF/ID must not take a new instruction.
- redirect_valid  in  1  branch/jump resolved taken; flush and redirect.
- redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0.
- imemREN  out  1  icache read enable.
- imemaddr  out  32  icache address; equals the PC register.
- ifinstr  out  32  instruction presented to IF/ID.
- ifJALjump_addr  out  32  PC+4 of the presented instruction.
- ifW  out  1  IF/ID write enable.
- ifRST  out  1  IF/ID flush; meaningful only with ifW=1.

Behaviour:
- Reset, on a rising CLK edge with nRST=0:
  - pc<=PC_INIT, state<=FETCH.
  - pend<=0, pend_pc<=0, buf<=0.
- Outputs:
  - imemaddr = pc, always.
  - ifinstr = buf in HOLD, else iload.
  - ifJALjump_addr = pc+4. The addition is 32-bit and wraps mod 2^32; the carry is dropped.
  - imemREN, ifW and ifRST are combinational from state and inputs. During reset all three are 0.
- Latency: ifinstr is valid in the same cycle as ihit. IF/ID captures it on the next edge. pc advances on that same edge.
- The icache address is held stable from imemREN assertion until ihit. pc never changes while a request is outstanding without an ihit.
- Priority, highest first: redirect_valid, pend, stall.
- State FETCH (imemREN=1):
  - redirect_valid=1: ifW=1, ifRST=1.
    - With ihit: the word is dropped, pc<=redirect_pc.
    - Without ihit: pend<=1, pend_pc<=redirect_pc, pc held.
  - else ihit and pend=1: word dropped (wrong path), ifW=0, pc<=pend_pc, pend<=0.
  - else ihit and stall=0: ifW=1, ifRST=0, pc<=pc+4.
    - If iload[31:26]==HALT_OP: go to HALTED, else stay in FETCH.
  - else ihit and stall=1: ifW=0, buf<=iload, go to HOLD.
  - else (no ihit): ifW=0, ifRST=0.
- State HOLD (imemREN=0):
  - redirect_valid=1: ifW=1, ifRST=1, pc<=redirect_pc, go to FETCH. buf is discarded.
  - else stall=0: ifW=1, pc<=pc+4.
    - If buf[31:26]==HALT_OP: go to HALTED, else go to FETCH.
  - else stay in HOLD, ifW=0.
- State HALTED (imemREN=0, ifW=0):
  - redirect_valid=1: ifW=1, ifRST=1, pc<=redirect_pc, go to FETCH. This covers a halt fetched on a wrong path.
  - otherwise stay in HALTED indefinitely; pc is held.
- Simultaneous redirect_valid and stall: the redirect wins. The flush write occurs even while stalled.
- A second redirect while pend=1 and still no ihit: pend_pc is overwritten; the last redirect wins.
- Reset mid-miss: state returns to FETCH with pend=0. A late ihit for the old address is treated as a hit on PC_INIT; the memory controller guarantees this cannot occur.

Decomposition:
- cpu_types_pkg (shared): word_t (32-bit), opcode_t, the HALT opcode constant, and the fetch state enum fetch_state_t {FETCH, HOLD, HALTED}.
- The PC+4 adder stays inline.
- One sub-module is natural: pc_reg. It holds pc, pend and pend_pc, with load/next-select inputs.

Test Plan:
- Reset then ihit=1 every cycle, stall=0, iload=0x2001_0005, 0x2002_0003 -> imemaddr 0x0, 0x4, 0x8. ifW=1 each cycle. ifJALjump_addr 0x4, 0x8.
- ihit at pc=0x10 with stall=1 for 3 cycles -> imemREN=0 and ifW=0 for 3 cycles. Then, with stall dropped: ifW=1, ifinstr=buffered word, pc becomes 0x14.
- At pc=0x20, miss held for 4 cycles; redirect_valid=1 with redirect_pc=0x100 in the second cycle -> ifW=1 and ifRST=1 that cycle, imemaddr stays 0x20. On ihit the word is dropped with ifW=0, then imemaddr=0x100.
- redirect_valid=1 and stall=1 together with redirect_pc=0x203 -> ifW=1, ifRST=1, next imemaddr=0x200.
- iload=0xFC00_0000 on ihit -> ifW=1 that cycle, then imemREN=0 and ifW=0 forever. Then redirect_valid with redirect_pc=0x40 -> flush, and fetching resumes at 0x40.
- pc=0xFFFF_FFFC with a hit -> ifJALjump_addr=0x0000_0000 and the next imemaddr=0x0.
